tdm_demux_1to4: RTL and testbench
=================================

TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

Interface
REQ-001 Parameter: DATA_W, 8, width of each time slot and each output lane.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  a slot beat is present on in_data this cycle.
REQ-005 Port: in_sof  input  1  start of frame; qualified by in_valid; marks slot 0.
REQ-006 Port: in_data  input  DATA_W  serial TDM slot payload.
REQ-007 Port: out_data0..out_data3  output  DATA_W each  lane registers for slots 0..3 (I0..I3 order).
REQ-008 Port: out_valid  output  4  one-cycle pulse per lane, bit k set when out_datak updated.
REQ-009 Port: frame_done  output  1  one-cycle pulse when slot 3 of a frame is written.
REQ-010 Port: sync_err  output  1  one-cycle pulse on any framing violation.
REQ-011 Port: locked  output  1  high while in SYNC state.

Function
REQ-012 The block SHALL implement a two-state FSM: HUNT (not framed) and SYNC (framed), with a 2-bit slot counter.
REQ-013 Beats with in_valid low SHALL be ignored; FSM, counter, lanes unchanged; out_valid, frame_done, sync_err low.
REQ-014 In HUNT, a beat with in_sof=0 SHALL be dropped silently (no sync_err).
REQ-015 In HUNT, a beat with in_sof=1 SHALL write lane 0, set counter to 1, enter SYNC.
REQ-016 In SYNC, a beat with in_sof=0 and counter=k (k=1..3) SHALL write lane k and increment counter modulo 4.
REQ-017 Writing lane 3 SHALL pulse frame_done in the same cycle as out_valid[3]; counter wraps to 0.
REQ-018 In SYNC with counter=0, a beat with in_sof=1 SHALL write lane 0 and set counter to 1 (normal back-to-back frame).
REQ-019 In SYNC with counter=0, a beat with in_sof=0 SHALL pulse sync_err, drop the beat, enter HUNT.
REQ-020 In SYNC with counter 1..3, a beat with in_sof=1 SHALL pulse sync_err, write lane 0, set counter to 1, stay in SYNC (resync; partial frame abandoned, no frame_done).
REQ-021 Latency: a beat accepted on edge N SHALL appear on out_datak and out_valid[k] after edge N (1 cycle); lane registers hold until next write to that lane.
REQ-022 At most one out_valid bit SHALL be high in any cycle.
REQ-023 locked SHALL equal (state==SYNC), registered.

Reset
REQ-024 On rst_n low, the block SHALL immediately set state=HUNT, counter=0, out_data0..3=0, out_valid=0, frame_done=0, sync_err=0, locked=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL require a new in_sof to lock.
REQ-026 The first rising edge with rst_n high SHALL be able to accept a beat.

Structure
REQ-027 A shared package tdm_pkg SHALL hold the FSM state enum (HUNT, SYNC), NUM_SLOTS=4, and SLOT_W=2.
REQ-028 The slot counter SHALL be a sub-module tdm_slot_ctr (load-1, increment-wrap, clear controls); all else stays in tdm_demux_1to4.
REQ-029 tdm_demux_1to4 SHALL be the receive-side counterpart of mux_4to1: slot k drives the lane that mux input Ik feeds.

Verification
REQ-030 Reset then frame {sof:0x0A, 0x0B, 0x0C, 0x0D} -> out_data0..3=0A,0B,0C,0D; out_valid 0001,0010,0100,1000 on successive cycles; frame_done with the last; locked=1 after first beat.
REQ-031 In HUNT, beats 0x11, 0x22 without sof then sof 0x33 -> first two dropped, no sync_err, out_data0=0x33, locked rises.
REQ-032 Locked, send sof 0x01, 0x02, then sof 0x05 -> sync_err pulse on third beat, out_data0=0x05, out_data1 keeps 0x02, no frame_done, then 3 more beats complete the frame normally.
REQ-033 Locked, complete frame, then non-sof 0x77 -> sync_err pulse, no lane written, locked=0.
REQ-034 Frame with in_valid gaps (0/1 alternating) -> same lane contents as gapless frame, outputs idle during gaps.
REQ-035 Assert rst_n low after slot 1 of a frame -> all outputs 0 asynchronously; post-release non-sof beats dropped until next sof.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 1-to-4 TDM demultiplexer.
// Provides the framing FSM state enum, the slot count and the slot counter width.
package tdm_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_e;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: wrapping slot counter for the TDM demultiplexer.
// Ports: clk, rst_n (async active-low), clr (force 0), load1 (force 1),
//        inc (advance modulo NUM_SLOTS), cnt (current slot index).
// Priority is clr > load1 > inc; with none asserted the count holds.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] cnt
);
    logic [SLOT_W-1:0] cnt_q, cnt_d;

    // Natural overflow of the SLOT_W-bit add gives the modulo-NUM_SLOTS wrap.
    always_comb
        cnt_d = clr ? '0 : load1 ? SLOT_W'(1) : inc ? cnt_q + SLOT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: receive-side TDM demultiplexer, one serial slot stream to four lanes.
// Ports: clk, rst_n (async active-low);
//        in_valid/in_sof/in_data  serial slot beats, in_sof marks slot 0;
//        out_data0..3             lane registers for slots 0..3 (mux inputs I0..I3);
//        out_valid[3:0]           one-cycle pulse, bit k when lane k is written;
//        frame_done               pulse when slot 3 completes a frame;
//        sync_err                 pulse on any framing violation;
//        locked                   high while framed (SYNC).
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [DATA_W-1:0]    in_data,
    output logic [DATA_W-1:0]    out_data0,
    output logic [DATA_W-1:0]    out_data1,
    output logic [DATA_W-1:0]    out_data2,
    output logic [DATA_W-1:0]    out_data3,
    output logic [NUM_SLOTS-1:0] out_valid,
    output logic                 frame_done,
    output logic                 sync_err,
    output logic                 locked
);
    state_e              state_q, state_d;
    logic [DATA_W-1:0]   lane_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] out_valid_q, out_valid_d;
    logic                frame_done_q, frame_done_d;
    logic                sync_err_q, sync_err_d;
    logic [SLOT_W-1:0]   cnt;
    logic                ld, inc, drop_lock;

    // Any valid sof beat starts a frame at slot 0, whatever the state.
    // Non-sof beats advance only mid-frame; a non-sof beat where slot 0 is due loses lock.
    always_comb begin
        ld           = in_valid && in_sof;
        inc          = in_valid && !in_sof && state_q == SYNC && cnt != '0;
        drop_lock    = in_valid && !in_sof && state_q == SYNC && cnt == '0;
        sync_err_d   = drop_lock || (ld && state_q == SYNC && cnt != '0);
        state_d      = ld ? SYNC : drop_lock ? HUNT : state_q;
        out_valid_d  = ld ? NUM_SLOTS'(1) : inc ? NUM_SLOTS'(1) << cnt : '0;
        frame_done_d = inc && cnt == SLOT_W'(NUM_SLOTS - 1);
    end

    tdm_slot_ctr u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (drop_lock),
        .load1 (ld),
        .inc   (inc),
        .cnt   (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            out_valid_q  <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) lane_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            if (ld)  lane_q[0]   <= in_data;
            if (inc) lane_q[cnt] <= in_data;
        end
    end

    assign out_data0  = lane_q[0];
    assign out_data1  = lane_q[1];
    assign out_data2  = lane_q[2];
    assign out_data3  = lane_q[3];
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = state_q == SYNC;
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: self-checking bench for tdm_demux_1to4 against a frame-position model.
module tb_tdm_demux_1to4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0] out_valid;
    logic       frame_done, sync_err, locked;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: m_pos = -1 when unframed, else the slot index the next non-sof beat belongs to.
    int         m_pos;
    logic [7:0] m_lane [4];
    logic [3:0] e_valid;
    logic       e_done, e_err;

    tdm_demux_1to4 #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_data3  (out_data3),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos   <= -1;
            for (int i = 0; i < 4; i++) m_lane[i] <= 8'h00;
            e_valid <= 4'b0;
            e_done  <= 1'b0;
            e_err   <= 1'b0;
        end else begin
            e_valid <= 4'b0;
            e_done  <= 1'b0;
            e_err   <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    e_err     <= m_pos > 0;
                    m_lane[0] <= in_data;
                    e_valid   <= 4'b0001;
                    m_pos     <= 1;
                end else if (m_pos == 0) begin
                    e_err <= 1'b1;
                    m_pos <= -1;
                end else if (m_pos > 0) begin
                    m_lane[m_pos] <= in_data;
                    e_valid       <= 4'(1 << m_pos);
                    e_done        <= m_pos == 3;
                    m_pos         <= (m_pos + 1) % 4;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("lane0", 32'(out_data0), 32'(m_lane[0]));
            check("lane1", 32'(out_data1), 32'(m_lane[1]));
            check("lane2", 32'(out_data2), 32'(m_lane[2]));
            check("lane3", 32'(out_data3), 32'(m_lane[3]));
            check("out_valid", 32'(out_valid), 32'(e_valid));
            check("frame_done", 32'(frame_done), 32'(e_done));
            check("sync_err", 32'(sync_err), 32'(e_err));
            check("locked", 32'(locked), 32'(m_pos >= 0));
            check("valid_onehot0", 32'($countones(out_valid) <= 1), 32'd1);
        end
    end

    task automatic beat(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_data0", 32'(out_data0), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean frame straight after reset.
        beat(1, 1, 8'h0A);
        check("f1_v0", 32'(out_valid), 32'b0001);
        check("f1_lock", 32'(locked), 32'h1);
        check("f1_d0", 32'(out_data0), 32'h0A);
        beat(1, 0, 8'h0B);
        check("f1_v1", 32'(out_valid), 32'b0010);
        beat(1, 0, 8'h0C);
        check("f1_v2", 32'(out_valid), 32'b0100);
        beat(1, 0, 8'h0D);
        check("f1_v3", 32'(out_valid), 32'b1000);
        check("f1_done", 32'(frame_done), 32'h1);
        check("f1_d1", 32'(out_data1), 32'h0B);
        check("f1_d3", 32'(out_data3), 32'h0D);

        // Missing sof where slot 0 is due: error and loss of lock.
        beat(1, 0, 8'h77);
        check("nosof_err", 32'(sync_err), 32'h1);
        check("nosof_valid", 32'(out_valid), 32'h0);
        check("nosof_lock", 32'(locked), 32'h0);
        check("nosof_d0", 32'(out_data0), 32'h0A);

        // Hunting: non-sof beats vanish silently until a sof arrives.
        beat(1, 0, 8'h11);
        check("hunt_err", 32'(sync_err), 32'h0);
        check("hunt_lock", 32'(locked), 32'h0);
        beat(1, 0, 8'h22);
        check("hunt_d1", 32'(out_data1), 32'h0B);
        beat(1, 1, 8'h33);
        check("hunt_d0", 32'(out_data0), 32'h33);
        check("hunt_relock", 32'(locked), 32'h1);
        beat(1, 0, 8'h34);
        beat(1, 0, 8'h35);
        beat(1, 0, 8'h36);

        // Early sof restarts the frame.
        beat(1, 1, 8'h01);
        beat(1, 0, 8'h02);
        beat(1, 1, 8'h05);
        check("rs_err", 32'(sync_err), 32'h1);
        check("rs_d0", 32'(out_data0), 32'h05);
        check("rs_d1", 32'(out_data1), 32'h02);
        check("rs_done", 32'(frame_done), 32'h0);
        beat(1, 0, 8'h06);
        beat(1, 0, 8'h07);
        beat(1, 0, 8'h08);
        check("rs_fin_done", 32'(frame_done), 32'h1);
        check("rs_fin_d1", 32'(out_data1), 32'h06);
        check("rs_fin_d3", 32'(out_data3), 32'h08);

        // Frame with idle cycles between beats.
        beat(1, 1, 8'hA1);
        beat(0, 0, 8'hFF);
        check("gap_idle", 32'(out_valid), 32'h0);
        beat(1, 0, 8'hA2);
        beat(0, 1, 8'hEE);
        check("gap_idle_sof", 32'(out_valid), 32'h0);
        beat(1, 0, 8'hA3);
        beat(0, 0, 8'h00);
        beat(1, 0, 8'hA4);
        check("gap_done", 32'(frame_done), 32'h1);
        check("gap_d0", 32'(out_data0), 32'hA1);
        check("gap_d2", 32'(out_data2), 32'hA3);

        // Reset mid-frame clears outputs without waiting for a clock edge.
        beat(1, 1, 8'hB1);
        beat(1, 0, 8'hB2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_d0", 32'(out_data0), 32'h0);
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_lock", 32'(locked), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        beat(1, 0, 8'hC1);
        check("post_rst_drop", 32'(out_valid), 32'h0);
        check("post_rst_lock", 32'(locked), 32'h0);
        beat(1, 1, 8'hC2);
        check("post_rst_sof", 32'(out_data0), 32'hC2);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) reset_pulse();
            else beat($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 8'($urandom));
        end

        beat(0, 0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
